// File: rtl/xh_cdb_txdat_sched.sv
// CDB TX data-channel scheduler: link activation FSM, link-credit accounting,
// round-robin arbitration of two requesters and credit return on deactivation.
module xh_cdb_txdat_sched #(
  parameter int unsigned FLIT_W  = 392,
  parameter int unsigned MAX_CRD = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [FLIT_W-1:0] req0_flit,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [FLIT_W-1:0] req1_flit,
  output logic              req1_ready,
  input  logic              link_en,
  output logic              txlinkactivereq,
  input  logic              txlinkactiveack,
  input  logic              rx_lcrdv,
  output logic              tx_flitpend,
  output logic              tx_flitv,
  output logic [FLIT_W-1:0] tx_flit,
  output logic              tx_lcrdret,
  output logic [3:0]        crd_cnt,
  output logic              err_crd_ovf
);

  localparam int unsigned CRD_W = 4;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    ACT   = 2'd1,
    RUN   = 2'd2,
    DEACT = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   prio1_q;
  logic   can_grant;
  logic   crd_ret;
  logic   issue;
  logic   crd_inc;

  // Grants, credit-return issue and credit gain for the current cycle
  always_comb begin
    can_grant       = (state_q == RUN) && (crd_cnt != '0);
    req0_ready      = can_grant && req0_valid && (!prio1_q || !req1_valid);
    req1_ready      = can_grant && req1_valid && (prio1_q || !req0_valid);
    crd_ret         = (state_q == DEACT) && (crd_cnt != '0);
    issue           = req0_ready || req1_ready || crd_ret;
    tx_flitpend     = issue;
    crd_inc         = rx_lcrdv && (state_q != STOP);
    txlinkactivereq = (state_q == ACT) || (state_q == RUN);
  end

  // Link activation next state; link_en is not looked at while draining credits
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    if (link_en) state_d = ACT;
      ACT:     if (txlinkactiveack) state_d = link_en ? RUN : DEACT;
      RUN:     if (!link_en) state_d = DEACT;
      DEACT:   if ((crd_cnt == '0) && !txlinkactiveack) state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STOP;
      prio1_q     <= 1'b0;
      crd_cnt     <= '0;
      err_crd_ovf <= 1'b0;
      tx_flitv    <= 1'b0;
      tx_lcrdret  <= 1'b0;
      tx_flit     <= '0;
    end else begin
      state_q    <= state_d;
      tx_flitv   <= issue;
      tx_lcrdret <= crd_ret;

      if (req0_ready) begin
        tx_flit <= req0_flit;
        prio1_q <= 1'b1;
      end else if (req1_ready) begin
        tx_flit <= req1_flit;
        prio1_q <= 1'b0;
      end else if (crd_ret) begin
        tx_flit <= '0;
      end

      // A credit gained and spent in the same cycle cancels out
      if (crd_inc && !issue) begin
        if (crd_cnt == CRD_W'(MAX_CRD)) err_crd_ovf <= 1'b1;
        else                            crd_cnt     <= crd_cnt + CRD_W'(1);
      end else if (issue && !crd_inc) begin
        crd_cnt <= crd_cnt - CRD_W'(1);
      end
    end
  end

endmodule

// File: doc/xh_cdb_txdat_sched.md
XH_CDB_TXDAT_SCHED -- requirements
Module: xh_cdb_txdat_sched

Interface
Parameters:
REQ-001 SHALL have parameter FLIT_W, default 392, data flit width.
REQ-002 SHALL have parameter MAX_CRD, default 15, maximum link credits held.

Ports:
REQ-003 SHALL have clk  in  1  single clock; reset is synchronous and active-high.
REQ-004 SHALL have rst  in  1  synchronous active-high reset.
REQ-005 SHALL have req0_valid / req1_valid  in  1 each  requester flit valid.
REQ-006 SHALL have req0_flit / req1_flit  in  FLIT_W each  requester flit payload.
REQ-007 SHALL have req0_ready / req1_ready  out  1 each  grant; a flit transfers when valid&ready.
REQ-008 SHALL have link_en  in  1  software request for link up (1) or link down (0).
REQ-009 SHALL have txlinkactivereq  out  1  link activation request to the CDB.
REQ-010 SHALL have txlinkactiveack  in  1  link activation acknowledge from the CDB.
REQ-011 SHALL have rx_lcrdv  in  1  one-cycle pulse returning one link credit.
REQ-012 SHALL have tx_flitpend  out  1  flit-valid pending, one cycle ahead of tx_flitv.
REQ-013 SHALL have tx_flitv  out  1  transmitted flit valid.
REQ-014 SHALL have tx_flit  out  FLIT_W  transmitted flit.
REQ-015 SHALL have tx_lcrdret  out  1  marks the current tx flit as a credit-return flit.
REQ-016 SHALL have crd_cnt  out  4  credits currently held.
REQ-017 SHALL have err_crd_ovf  out  1  sticky credit-overflow error.

Function
REQ-018 SHALL implement FSM states STOP, ACT, RUN, DEACT; txlinkactivereq=1 only in ACT and RUN.
REQ-019 STOP->ACT when link_en=1; ACT->RUN when txlinkactiveack=1; RUN->DEACT when link_en=0; ACT with link_en=0 and ack=1 -> DEACT.
REQ-020 DEACT->STOP when crd_cnt=0 and txlinkactiveack=0, in the same cycle the condition holds.
REQ-021 rx_lcrdv SHALL increment crd_cnt in ACT, RUN and DEACT; it SHALL be ignored in STOP.
REQ-022 Each flit issued (requester or credit return) SHALL decrement crd_cnt; simultaneous increment and decrement leaves it unchanged.
REQ-023 rx_lcrdv with crd_cnt=MAX_CRD and no decrement SHALL saturate the count and set err_crd_ovf until rst.
REQ-024 Grant SHALL be possible only in RUN with crd_cnt>0; readys are combinational; at most one ready per cycle.
REQ-025 Arbitration SHALL be round-robin: after a grant to reqN, the other requester has priority; after reset, req0 has priority.
REQ-026 A granted flit SHALL appear on tx_flit with tx_flitv=1 exactly one cycle after the handshake cycle.
REQ-027 tx_flitpend SHALL be 1 in any cycle in which a flit is issued (handshake or credit return).
REQ-028 In DEACT, each cycle with crd_cnt>0 SHALL issue a credit-return flit: tx_flit all zeros, tx_lcrdret=1 (with tx_flitv one cycle later).
REQ-029 In DEACT, requester readys SHALL be 0.
REQ-030 tx_lcrdret SHALL be 0 for requester flits; tx_flit holds its last value when tx_flitv=0.
REQ-031 link_en reasserted during DEACT SHALL be ignored until STOP is reached.

Reset
REQ-032 rst SHALL force STOP, crd_cnt=0, err_crd_ovf=0, priority to req0, and all outputs (txlinkactivereq, tx_flitpend, tx_flitv, tx_lcrdret, readys, tx_flit) to 0 on the next edge, including mid-transfer.
REQ-033 A flit handshaked in the cycle rst is asserted SHALL be discarded.

Verification
REQ-034 link_en=1, ack 2 cycles later -> STOP, ACT, RUN; txlinkactivereq rises 1 cycle after link_en.
REQ-035 In RUN, 3 rx_lcrdv pulses, then both requesters valid for 4 cycles -> grants req0, req1, req0; 4th cycle no ready (crd_cnt=0); tx_flitv high 3 cycles, each lagging its grant by 1.
REQ-036 crd_cnt=5, rx_lcrdv in the same cycle as a grant -> crd_cnt stays 5.
REQ-037 16 rx_lcrdv pulses with no traffic -> crd_cnt=15, err_crd_ovf=1 and it stays 1 until rst.
REQ-038 RUN with crd_cnt=3, link_en=0 -> DEACT, 3 return flits (tx_lcrdret=1, tx_flit=0); ack drops -> STOP.
REQ-039 rst asserted during a handshake in RUN -> next cycle tx_flitv=0, crd_cnt=0, state STOP.
